// File: rtl/sram_b_fifo_ctrl.sv
// Valid/ready FIFO controller for a 1w:1r sram_b macro, with a 2-entry output
// prefetch buffer that hides the one-cycle SRAM read latency.
module sram_b_fifo_ctrl #(
    parameter int ABITS  = 6,
    parameter int DWIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [ABITS+1:0]  count,
    output logic              mem_CE0,
    output logic [ABITS-1:0]  mem_A0,
    output logic [DWIDTH-1:0] mem_D0,
    output logic              mem_WE0,
    output logic [DWIDTH-1:0] mem_WEM0,
    output logic              mem_CE1,
    output logic [ABITS-1:0]  mem_A1,
    input  logic [DWIDTH-1:0] mem_Q1
);
    localparam int DEPTH = 2 ** ABITS;
    localparam logic [ABITS:0] DEPTH_C = (ABITS+1)'(DEPTH);

    logic [ABITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ABITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ABITS:0]    sram_cnt_q, sram_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic [DWIDTH-1:0] buf0_q, buf0_d;
    logic [DWIDTH-1:0] buf1_q, buf1_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [ABITS+1:0]  count_q, count_d;

    logic push;
    logic pop;
    logic issue;
    logic [2:0] pending;

    // clear suppresses every handshake and SRAM access in its cycle
    assign push    = in_valid && in_ready_q && !clear;
    assign pop     = out_valid_q && out_ready && !clear;
    assign pending = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    assign issue   = !clear && (sram_cnt_q != '0) && (pending < (3'd2 + {2'b00, pop}));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sram_cnt_d = sram_cnt_q;
        inflight_d = 1'b0;
        buf_cnt_d  = buf_cnt_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            sram_cnt_d = '0;
            buf_cnt_d  = '0;
        end else begin
            wr_ptr_d   = wr_ptr_q + ABITS'(push);
            rd_ptr_d   = rd_ptr_q + ABITS'(issue);
            sram_cnt_d = sram_cnt_q + (ABITS+1)'(push) - (ABITS+1)'(issue);
            inflight_d = issue;
            // shift out the head first, then land the returning read at the new tail
            if (pop) begin
                buf0_d    = buf1_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            if (inflight_q) begin
                if (buf_cnt_d == 2'd0) begin
                    buf0_d = mem_Q1;
                end else begin
                    buf1_d = mem_Q1;
                end
                buf_cnt_d = buf_cnt_d + 2'd1;
            end
        end
        in_ready_d  = sram_cnt_d < DEPTH_C;
        out_valid_d = buf_cnt_d != 2'd0;
        count_d     = (ABITS+2)'(sram_cnt_d) + (ABITS+2)'(inflight_d) + (ABITS+2)'(buf_cnt_d);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sram_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            buf_cnt_q   <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sram_cnt_q  <= sram_cnt_d;
            inflight_q  <= inflight_d;
            buf_cnt_q   <= buf_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = buf0_q;
    assign count     = count_q;

    // Address/data buses are zeroed when idle so the macro sees clean inputs
    assign mem_CE0  = push;
    assign mem_WE0  = push;
    assign mem_WEM0 = {DWIDTH{push}};
    assign mem_A0   = push ? wr_ptr_q : '0;
    assign mem_D0   = push ? in_data : '0;
    assign mem_CE1  = issue;
    assign mem_A1   = issue ? rd_ptr_q : '0;

endmodule

// File: tb/tb_sram_b_fifo_ctrl.sv
// Randomized bench for sram_b_fifo_ctrl: behavioural SRAM plus a queue-based
// FIFO reference model; each scenario task checks its own results inline.
module tb_sram_b_fifo_ctrl;
    localparam int ABITS = 6;
    localparam int DW    = 8;
    localparam int CAP   = 66;

    logic          CLK = 1'b0;
    logic          RST;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [ABITS+1:0] count;
    logic          mem_CE0;
    logic [ABITS-1:0] mem_A0;
    logic [DW-1:0] mem_D0;
    logic          mem_WE0;
    logic [DW-1:0] mem_WEM0;
    logic          mem_CE1;
    logic [ABITS-1:0] mem_A1;
    logic [DW-1:0] mem_Q1;

    logic [DW-1:0] sram_m [64];
    logic [DW-1:0] q1_m;
    logic [DW-1:0] model_q [$];

    int checks = 0;
    int errors = 0;

    sram_b_fifo_ctrl #(.ABITS(ABITS), .DWIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .mem_CE0(mem_CE0), .mem_A0(mem_A0), .mem_D0(mem_D0),
        .mem_WE0(mem_WE0), .mem_WEM0(mem_WEM0),
        .mem_CE1(mem_CE1), .mem_A1(mem_A1), .mem_Q1(mem_Q1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_CE0 && mem_WE0)
            sram_m[mem_A0] <= (mem_D0 & mem_WEM0) | (sram_m[mem_A0] & ~mem_WEM0);
        if (mem_CE1)
            q1_m <= sram_m[mem_A1];
    end
    assign mem_Q1 = q1_m;

    // Called at the negative edge: records this cycle's handshakes in the
    // reference queue, then advances to just after the next rising edge.
    task automatic tick(output bit pushed, output bit popped,
                        output logic [DW-1:0] got, output logic [DW-1:0] exp,
                        output bit conflict);
        pushed   = in_valid && in_ready && !clear && !RST;
        popped   = out_valid && out_ready && !clear && !RST;
        got      = out_data;
        exp      = 'x;
        conflict = mem_CE0 && mem_CE1 && (mem_A0 == mem_A1);
        if (clear) model_q.delete();
        if (popped && model_q.size() > 0) exp = model_q.pop_front();
        if (pushed) model_q.push_back(in_data);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== '0 || mem_CE0 !== 1'b0 || mem_CE1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b count=%0d CE0=%b CE1=%b, required 0 0 0 0 0",
                         in_ready, out_valid, count, mem_CE0, mem_CE1);
            end
            @(posedge CLK); #1;
        end
        RST = 1'b0; in_valid = 1'b0;
        model_q.delete();
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_pre: in_ready=%b required 0", in_ready);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL reset_release_post: in_ready=%b count=%0d required 1 0", in_ready, count);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_latency();
        bit pu, po, cf;
        logic [DW-1:0] g, e;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        @(negedge CLK);
        checks++;
        if (mem_CE0 !== 1'b1 || mem_WE0 !== 1'b1 || mem_A0 !== '0 || mem_D0 !== 8'hA5 || mem_WEM0 !== 8'hFF) begin
            errors++;
            $display("FAIL lat_write: CE0=%b WE0=%b A0=%0d D0=%h WEM0=%h required 1 1 0 a5 ff",
                     mem_CE0, mem_WE0, mem_A0, mem_D0, mem_WEM0);
        end
        tick(pu, po, g, e, cf);
        in_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (mem_CE1 !== 1'b1 || mem_A1 !== '0 || mem_CE0 !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_issue: CE1=%b A1=%0d CE0=%b out_valid=%b required 1 0 0 0",
                     mem_CE1, mem_A1, mem_CE0, out_valid);
        end
        tick(pu, po, g, e, cf);
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_cycle2: out_valid=%b required 0", out_valid);
        end
        tick(pu, po, g, e, cf);
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== 8'd1) begin
            errors++;
            $display("FAIL lat_cycle3: out_valid=%b out_data=%h count=%0d required 1 a5 1",
                     out_valid, out_data, count);
        end
        tick(pu, po, g, e, cf);
        @(negedge CLK);
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_after_pop: count=%0d out_valid=%b required 0 0", count, out_valid);
        end
        tick(pu, po, g, e, cf);
    endtask

    task automatic test_fill();
        bit pu, po, cf;
        logic [DW-1:0] g, e;
        int acc = 0;
        int n = 0;
        int cyc = 0;
        out_ready = 1'b0;
        while (acc < CAP && cyc < 300) begin
            in_valid = 1'b1; in_data = 8'(acc);
            @(negedge CLK);
            checks++;
            if (count !== 8'(model_q.size())) begin
                errors++;
                $display("FAIL fill_count: count=%0d required %0d", count, model_q.size());
            end
            tick(pu, po, g, e, cf);
            if (pu) acc++;
            cyc++;
        end
        checks++;
        if (acc != CAP) begin
            errors++;
            $display("FAIL fill_timeout: accepted %0d required %0d", acc, CAP);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h42;
            @(negedge CLK);
            checks++;
            if (in_ready !== 1'b0 || count !== 8'(CAP) || mem_CE0 !== 1'b0) begin
                errors++;
                $display("FAIL fill_full: in_ready=%b count=%0d CE0=%b required 0 66 0", in_ready, count, mem_CE0);
            end
            tick(pu, po, g, e, cf);
        end
        in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (n < CAP && cyc < 300) begin
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            if (po) begin
                checks++;
                if (g !== 8'(n) || g !== e) begin
                    errors++;
                    $display("FAIL fill_drain_data: got %h required %h", g, 8'(n));
                end
                n++;
            end
            cyc++;
        end
        @(negedge CLK);
        checks++;
        if (n != CAP || count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain_end: popped %0d count=%0d out_valid=%b required 66 0 0", n, count, out_valid);
        end
        tick(pu, po, g, e, cf);
    endtask

    task automatic test_streaming();
        bit pu, po, cf;
        logic [DW-1:0] g, e;
        int first = -1;
        int cyc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data = 8'(8'h40 + i);
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            checks++;
            if (cf) begin
                errors++;
                $display("FAIL stream_addr_conflict: cycle %0d same address written and read", i);
            end
            if (po) begin
                if (first < 0) first = i;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL stream_data: cycle %0d got %h required %h", i, g, e);
                end
            end else if (first >= 0) begin
                checks++;
                errors++;
                $display("FAIL stream_gap: cycle %0d popped 0 required 1", i);
            end
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL stream_first_out: cycle %0d required 3", first);
        end
        in_valid = 1'b0;
        while (model_q.size() > 0 && cyc < 50) begin
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            if (po) begin
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL stream_drain: got %h required %h", g, e);
                end
            end
            cyc++;
        end
    endtask

    task automatic test_backpressure();
        bit pu, po, cf;
        logic [DW-1:0] g, e;
        int sent = 0;
        int cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(99) < 70);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(99) < 30);
            @(negedge CLK);
            checks++;
            if (count > 8'(CAP) || count !== 8'(model_q.size())) begin
                errors++;
                $display("FAIL bp_count: count=%0d required %0d (max 66)", count, model_q.size());
            end
            tick(pu, po, g, e, cf);
            checks++;
            if (cf || (po && g !== e)) begin
                errors++;
                $display("FAIL bp_data: conflict=%b got %h required %h", cf, g, e);
            end
            if (pu) sent++;
            cyc++;
        end
        checks++;
        if (sent != 1000) begin
            errors++;
            $display("FAIL bp_timeout: sent %0d required 1000", sent);
        end
        in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
        while (model_q.size() > 0 && cyc < 200) begin
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            if (po) begin
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL bp_drain: got %h required %h", g, e);
                end
            end
            cyc++;
        end
        @(negedge CLK);
        checks++;
        if (count !== '0 || model_q.size() != 0) begin
            errors++;
            $display("FAIL bp_end: count=%0d model=%0d required 0 0", count, model_q.size());
        end
        tick(pu, po, g, e, cf);
    endtask

    task automatic test_clear();
        bit pu, po, cf;
        logic [DW-1:0] g, e;
        int acc = 0;
        int cyc = 0;
        bit seen = 1'b0;
        out_ready = 1'b0;
        while (acc < 10 && cyc < 50) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + acc);
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            if (pu) acc++;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            tick(pu, po, g, e, cf);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (mem_CE1 !== 1'b1) begin
            errors++;
            $display("FAIL clear_setup_issue: CE1=%b required 1", mem_CE1);
        end
        tick(pu, po, g, e, cf);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        @(negedge CLK);
        checks++;
        if (mem_CE0 !== 1'b0 || mem_CE1 !== 1'b0) begin
            errors++;
            $display("FAIL clear_mem_quiet: CE0=%b CE1=%b required 0 0", mem_CE0, mem_CE1);
        end
        tick(pu, po, g, e, cf);
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_state: count=%0d out_valid=%b in_ready=%b required 0 0 1", count, out_valid, in_ready);
        end
        tick(pu, po, g, e, cf);
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (count !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_quiet: count=%0d out_valid=%b required 0 0", count, out_valid);
            end
            tick(pu, po, g, e, cf);
        end
        in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
        @(negedge CLK);
        tick(pu, po, g, e, cf);
        in_valid = 1'b0; cyc = 0;
        while (!seen && cyc < 10) begin
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            if (po) begin
                seen = 1'b1;
                checks++;
                if (g !== 8'h33) begin
                    errors++;
                    $display("FAIL clear_first_out: got %h required 33", g);
                end
            end
            cyc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL clear_no_output: nothing popped, required 33");
        end
    endtask

    task automatic test_async_reset();
        bit pu, po, cf;
        logic [DW-1:0] g, e;
        int cyc = 0;
        bit seen = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            if (po) begin
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL arst_stream: got %h required %h", g, e);
                end
            end
        end
        in_valid = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        model_q.delete();
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || mem_CE0 !== 1'b0 || mem_CE1 !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: count=%0d out_valid=%b in_ready=%b CE0=%b CE1=%b required 0 0 0 0 0",
                     count, out_valid, in_ready, mem_CE0, mem_CE1);
        end
        @(negedge CLK);
        tick(pu, po, g, e, cf);
        RST = 1'b0; in_valid = 1'b0;
        @(negedge CLK);
        tick(pu, po, g, e, cf);
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1 || count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_release: in_ready=%b count=%0d out_valid=%b required 1 0 0", in_ready, count, out_valid);
        end
        tick(pu, po, g, e, cf);
        in_valid = 1'b1; in_data = 8'h5C;
        @(negedge CLK);
        tick(pu, po, g, e, cf);
        in_valid = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge CLK);
            tick(pu, po, g, e, cf);
            if (po) begin
                seen = 1'b1;
                checks++;
                if (g !== 8'h5C) begin
                    errors++;
                    $display("FAIL arst_first_out: got %h required 5c", g);
                end
            end
            cyc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL arst_no_output: nothing popped, required 5c");
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_streaming();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_b_fifo_ctrl.md
Name: sram_b_fifo_ctrl

Overview:
- Streaming FIFO controller that drives one 1w:1r sram_b macro: write port (CE0/A0/D0/WE0/WEM0) and read port (CE1/A1, Q1 with 1-cycle latency).
- Turns the raw SRAM into a valid/ready FIFO for accelerator data buffering.
- A 2-entry output prefetch buffer hides the SRAM read latency and sustains 1 transfer/cycle.
- Sits directly upstream of the SRAM instance; its mem_* ports connect 1:1 to the macro ports.

Parameters:
- ABITS, 6, SRAM address width; SRAM depth DEPTH = 2**ABITS (64).
- DWIDTH, 8, data width; must equal SRAM word width.

Ports:
- CLK  in  1  single clock; all state on posedge.
- RST  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush, 1-cycle pulse.
- in_valid  in  1  producer has data.
- in_ready  out  1  registered; FIFO accepts data.
- in_data  in  DWIDTH  write data.
- out_valid  out  1  registered; out_data valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DWIDTH  registered head-of-FIFO data.
- count  out  ABITS+2  total occupancy: SRAM + in-flight read + buffer.
- mem_CE0  out  1  SRAM write-port enable.
- mem_A0  out  ABITS  write address.
- mem_D0  out  DWIDTH  write data.
- mem_WE0  out  1  write enable.
- mem_WEM0  out  DWIDTH  write mask.
- mem_CE1  out  1  SRAM read-port enable.
- mem_A1  out  ABITS  read address.
- mem_Q1  in  DWIDTH  read data, valid the cycle after mem_CE1.

Behaviour:
- Reset is asynchronous and active-high; the clock is CLK and the reset is RST.
- RST asserted values: wr_ptr=0, rd_ptr=0, sram_cnt=0, inflight=0, buf_cnt=0, in_ready=0, out_valid=0, out_data=0, count=0.
- All mem_* outputs are 0 while RST is high.
- First posedge after RST release: in_ready=1.
- Push: when in_valid && in_ready, drive mem_CE0=1, mem_WE0=1, mem_WEM0=all ones, mem_A0=wr_ptr, mem_D0=in_data in the same cycle. wr_ptr increments mod DEPTH.
- No push: mem_CE0=mem_WE0=0, mem_WEM0=0.
- in_ready (registered) = next sram_cnt < DEPTH. It does not depend on in_valid or out_ready combinationally.
- Read issue (combinational) when sram_cnt>0 && (buf_cnt + inflight - pop) < 2, where pop = out_valid && out_ready.
  - On issue: mem_CE1=1, mem_A1=rd_ptr; rd_ptr increments mod DEPTH; inflight<=1 next cycle, else 0.
- inflight=1: mem_Q1 is written into the buffer tail at the end of that cycle. buf_cnt = buf_cnt + inflight - pop.
- out_data/out_valid always present the buffer head. On pop, the second entry (if any) shifts to head in the same edge.
- sram_cnt update per edge: +push, -issue, both in the same cycle leave it unchanged.
- Latency: push at cycle 0 -> read issue cycle 1 -> Q1 cycle 2 -> out_valid=1 in cycle 3 (empty FIFO).
- Throughput: steady state with in_valid=out_ready=1 gives 1 push and 1 pop per cycle with no bubbles.
- Capacity: DEPTH+2. in_ready drops when the SRAM holds DEPTH and the buffer holds 2.
- Address conflict: a same-cycle write and read never target the same address. A write needs sram_cnt<DEPTH and a read needs sram_cnt>0, so the pointers are unequal whenever both are active.
- count = sram_cnt + inflight + buf_cnt, registered, with the same update timing as the state.
- clear: on the next edge, pointers, counts, inflight and buf_cnt go to 0 and out_valid goes to 0.
  - A push or pop in the clear cycle is discarded. An in-flight read result is dropped.
  - in_ready=1 after clear.
  - clear has priority over all other activity.
- Order: strict FIFO order across pointer wrap at DEPTH-1 -> 0.
- RST mid-operation: immediate return to reset values, independent of CLK. The SRAM contents are irrelevant afterwards.

Test Plan:
- Reset: hold RST 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0, no mem_CE0/mem_CE1. Release -> in_ready=1 after 1 edge.
- Latency: push 0xA5 into an empty FIFO at cycle 0 with out_ready=1 -> mem_CE1=1, A1=0 at cycle 1; out_valid=1 and out_data=0xA5 at cycle 3; count returns to 0 after the pop.
- Fill: out_ready=0, push 0x00..0x41 (66 words) -> in_ready=0 after the 66th, count=66, 67th not accepted. Drain -> 0x00..0x41 in order.
- Streaming: in_valid=out_ready=1 for 200 cycles with an incrementing pattern -> one output per cycle after a 3-cycle fill, no gaps. Data is correct across pointer wrap; no same-address write/read.
- Backpressure: random out_ready at 30% and random in_valid at 70%, 1000 words -> output matches the reference queue exactly; count is never >66.
- clear/RST: push 10, pulse clear in a cycle with a read in flight -> count=0, out_valid=0 next cycle. A new push of 0x33 appears as the first output. Repeat with asynchronous RST mid-stream -> same empty state.
